// File: rtl/lmac_fcs_pkg.sv
// Shared constants, types and helpers for the Ethernet FCS sequencer.
package lmac_fcs_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BCNT_W = 2;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    APPEND
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
    logic [BCNT_W-1:0] bcnt;
  } beat_t;

  // Bit-reverse a 32-bit word (normal polynomial -> LSB-first form).
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Beat byte-count encoding: 0 means a full 4-byte beat.
  function automatic logic [2:0] bcnt_bytes(input logic [BCNT_W-1:0] bcnt);
    return (bcnt == 2'd0) ? 3'd4 : {1'b0, bcnt};
  endfunction

endpackage

// File: rtl/lmac_fcs_ctrl_crc32_d8_step.sv
// One byte of reflected CRC-32 update (LSB of the byte enters first).
module crc32_d8_step
  import lmac_fcs_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  logic [31:0] crc_w;

  always_comb begin
    crc_w = crc_in ^ {24'd0, data_in};
    for (int i = 0; i < 8; i++) begin
      crc_w = crc_w[0] ? ((crc_w >> 1) ^ POLY_R) : (crc_w >> 1);
    end
    crc_out = crc_w;
  end

endmodule

// File: rtl/lmac_fcs_ctrl.sv
// Frame sequencer for the FCS datapath: appends FCS in generate mode,
// checks the CRC residue in check mode, behind a 1-cycle register slice.
module lmac_fcs_ctrl
  import lmac_fcs_pkg::*;
#(
  parameter logic [31:0] CRC_INIT    = CRC32_INIT,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_check,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eof,
  input  logic [BCNT_W-1:0] s_bcnt,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic [BCNT_W-1:0] m_bcnt,
  output logic [31:0]       crc_value,
  output logic              stat_valid,
  output logic              stat_crc_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [31:0]       crc_q, crc_d;
  beat_t             out_q, out_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [BCNT_W-1:0] hold_bcnt_q, hold_bcnt_d;
  logic [31:0]       crc_value_q, crc_value_d;
  logic              stat_valid_q, stat_valid_d;
  logic              stat_err_q, stat_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              out_free;
  logic              accept;
  logic              frame_mode;
  logic [31:0]       crc_base;
  logic [31:0]       tap [0:4];
  logic [31:0]       crc_tap;
  logic [31:0]       fcs;
  logic [2:0]        n_bytes;
  logic [5:0]        lane_sh;
  logic [5:0]        rem_sh;
  logic [DATA_W-1:0] data_kept;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] extra;

  assign out_free   = !m_valid_q || m_ready;
  assign s_ready    = (state_q != APPEND) && out_free;
  assign accept     = s_valid && s_ready;
  assign frame_mode = s_sof ? cfg_check : mode_q;
  assign crc_base   = ((state_q == IDLE) || s_sof) ? CRC_INIT : crc_q;

  // Four chained byte steps, lane 0 first.
  assign tap[0] = crc_base;
  for (genvar g = 0; g < 4; g++) begin : g_step
    crc32_d8_step u_step (
      .crc_in  (tap[g]),
      .data_in (s_data[8*g +: 8]),
      .crc_out (tap[g+1])
    );
  end

  always_comb begin
    crc_tap = tap[4];
    if (s_eof) begin
      case (s_bcnt)
        2'd1:    crc_tap = tap[1];
        2'd2:    crc_tap = tap[2];
        2'd3:    crc_tap = tap[3];
        default: crc_tap = tap[4];
      endcase
    end
  end

  // FCS lane placement: first part fills the EOF tail, remainder goes to the extra beat.
  assign fcs       = ~crc_tap;
  assign n_bytes   = bcnt_bytes(s_bcnt);
  assign lane_sh   = {n_bytes, 3'b000};
  assign rem_sh    = 6'd32 - lane_sh;
  assign data_kept = s_data & (32'hFFFF_FFFF >> rem_sh);
  assign merged    = data_kept | (fcs << lane_sh);
  assign extra     = fcs >> rem_sh;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    crc_d        = crc_q;
    out_d        = out_q;
    m_valid_d    = m_valid_q;
    hold_data_d  = hold_data_q;
    hold_bcnt_d  = hold_bcnt_q;
    crc_value_d  = crc_value_q;
    stat_valid_d = 1'b0;
    stat_err_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (out_free) m_valid_d = 1'b0;

    case (state_q)
      APPEND: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          out_d     = '{data: hold_data_q, sof: 1'b0, eof: 1'b1, bcnt: hold_bcnt_q};
          state_d   = IDLE;
        end
      end
      default: begin
        // Non-SOF beats while idle are accepted and dropped.
        if (accept && ((state_q == FRAME) || s_sof)) begin
          mode_d    = frame_mode;
          m_valid_d = 1'b1;
          out_d     = '{data: s_data, sof: s_sof, eof: 1'b0, bcnt: 2'd0};
          if (!s_eof) begin
            crc_d   = tap[4];
            state_d = FRAME;
          end else begin
            crc_d        = CRC_INIT;
            crc_value_d  = fcs;
            stat_valid_d = 1'b1;
            if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (frame_mode) begin
              out_d.data = data_kept;
              out_d.eof  = 1'b1;
              out_d.bcnt = s_bcnt;
              stat_err_d = (crc_tap != CRC_RESIDUE);
              if (stat_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
              state_d    = IDLE;
            end else begin
              out_d.data  = merged;
              hold_data_d = extra;
              hold_bcnt_d = s_bcnt;
              state_d     = APPEND;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      crc_q        <= CRC_INIT;
      out_q        <= '0;
      m_valid_q    <= 1'b0;
      hold_data_q  <= '0;
      hold_bcnt_q  <= '0;
      crc_value_q  <= '0;
      stat_valid_q <= 1'b0;
      stat_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      crc_q        <= crc_d;
      out_q        <= out_d;
      m_valid_q    <= m_valid_d;
      hold_data_q  <= hold_data_d;
      hold_bcnt_q  <= hold_bcnt_d;
      crc_value_q  <= crc_value_d;
      stat_valid_q <= stat_valid_d;
      stat_err_q   <= stat_err_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = out_q.data;
  assign m_sof        = out_q.sof;
  assign m_eof        = out_q.eof;
  assign m_bcnt       = out_q.bcnt;
  assign crc_value    = crc_value_q;
  assign stat_valid   = stat_valid_q;
  assign stat_crc_err = stat_err_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_lmac_fcs_ctrl.sv
// Directed self-checking bench for lmac_fcs_ctrl using known CRC-32 vectors.
module tb_lmac_fcs_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_check;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_sof;
  logic        s_eof;
  logic [1:0]  s_bcnt;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sof;
  logic        m_eof;
  logic [1:0]  m_bcnt;
  logic [31:0] crc_value;
  logic        stat_valid;
  logic        stat_crc_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic [1:0]  bcnt;
  } obs_t;

  obs_t obs_w;
  obs_t mon_q [$];
  logic stat_q [$];

  lmac_fcs_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_check    (cfg_check),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_eof        (s_eof),
    .s_bcnt       (s_bcnt),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sof        (m_sof),
    .m_eof        (m_eof),
    .m_bcnt       (m_bcnt),
    .crc_value    (crc_value),
    .stat_valid   (stat_valid),
    .stat_crc_err (stat_crc_err),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture accepted output beats and stat pulses mid-cycle.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      obs_w.data = m_data;
      obs_w.sof  = m_sof;
      obs_w.eof  = m_eof;
      obs_w.bcnt = m_bcnt;
      mon_q.push_back(obs_w);
    end
    if (stat_valid) stat_q.push_back(stat_crc_err);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic sof, input logic eof,
                      input logic [1:0] bcnt, input logic chk);
    bit got;
    got       = 1'b0;
    s_valid   = 1'b1;
    s_data    = d;
    s_sof     = sof;
    s_eof     = eof;
    s_bcnt    = bcnt;
    cfg_check = chk;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    if (!got) check("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic sof,
                             input logic eof, input logic [1:0] bcnt);
    obs_t b;
    if (mon_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      b = mon_q.pop_front();
      check({tag, "_data"}, b.data, d);
      check({tag, "_flags"}, {28'd0, b.sof, b.eof, b.bcnt}, {28'd0, sof, eof, bcnt});
    end
  endtask

  task automatic expect_stat(input string tag, input logic err);
    logic e;
    if (stat_q.size() == 0) begin
      check({tag, "_stat_present"}, 32'd0, 32'd1);
    end else begin
      e = stat_q.pop_front();
      check({tag, "_stat_err"}, 32'(e), 32'(err));
    end
  endtask

  task automatic gen_123456789(input string tag);
    send(32'h3433_3231, 1'b1, 1'b0, 2'd0, 1'b0);
    send(32'h3837_3635, 1'b0, 1'b0, 2'd0, 1'b0);
    send(32'h0000_0039, 1'b0, 1'b1, 2'd1, 1'b0);
    cycles(4);
    expect_beat({tag, "_b0"}, 32'h3433_3231, 1'b1, 1'b0, 2'd0);
    expect_beat({tag, "_b1"}, 32'h3837_3635, 1'b0, 1'b0, 2'd0);
    expect_beat({tag, "_b2"}, 32'hF439_2639, 1'b0, 1'b0, 2'd0);
    expect_beat({tag, "_b3"}, 32'h0000_00CB, 1'b0, 1'b1, 2'd1);
    check({tag, "_extra_beats"}, 32'(mon_q.size()), 32'd0);
    check({tag, "_crc_value"}, crc_value, 32'hCBF4_3926);
    expect_stat(tag, 1'b0);
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] b1);
    send(32'h3433_3231, 1'b1, 1'b0, 2'd0, 1'b1);
    send(b1,            1'b0, 1'b0, 2'd0, 1'b0);
    send(32'hF439_2639, 1'b0, 1'b0, 2'd0, 1'b0);
    send(32'h0000_00CB, 1'b0, 1'b1, 2'd1, 1'b0);
    cycles(3);
    expect_beat({tag, "_b0"}, 32'h3433_3231, 1'b1, 1'b0, 2'd0);
    expect_beat({tag, "_b1"}, b1,            1'b0, 1'b0, 2'd0);
    expect_beat({tag, "_b2"}, 32'hF439_2639, 1'b0, 1'b0, 2'd0);
    expect_beat({tag, "_b3"}, 32'h0000_00CB, 1'b0, 1'b1, 2'd1);
  endtask

  initial begin
    rst       = 1'b0;
    cfg_check = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_sof     = 1'b0;
    s_eof     = 1'b0;
    s_bcnt    = '0;
    m_ready   = 1'b1;
    cycles(3);

    check("rst_m_valid",    32'(m_valid), 32'd0);
    check("rst_stat_valid", 32'(stat_valid), 32'd0);
    check("rst_frame_cnt",  32'(frame_cnt), 32'd0);
    check("rst_err_cnt",    32'(err_cnt), 32'd0);
    check("rst_crc_value",  crc_value, 32'd0);
    check("rst_s_ready",    32'(s_ready), 32'd1);
    rst = 1'b1;
    cycles(2);

    // Generate mode, "123456789" with one-byte EOF beat.
    gen_123456789("gen9");
    check("gen9_frame_cnt", 32'(frame_cnt), 32'd1);

    // Generate mode, single full beat: whole FCS goes to the extra beat.
    send(32'h3433_3231, 1'b1, 1'b1, 2'd0, 1'b0);
    cycles(4);
    expect_beat("gen4_b0", 32'h3433_3231, 1'b1, 1'b0, 2'd0);
    expect_beat("gen4_b1", 32'h9BE3_E0A3, 1'b0, 1'b1, 2'd0);
    check("gen4_crc_value", crc_value, 32'h9BE3_E0A3);
    check("gen4_frame_cnt", 32'(frame_cnt), 32'd2);
    expect_stat("gen4", 1'b0);

    // Beat without SOF while idle is dropped.
    send(32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 1'b0);
    cycles(3);
    check("drop_no_output", 32'(mon_q.size()), 32'd0);
    check("drop_frame_cnt", 32'(frame_cnt), 32'd2);

    // Check mode, good frame with FCS.
    chk_frame("chk_good", 32'h3837_3635);
    expect_stat("chk_good", 1'b0);
    check("chk_good_err_cnt",   32'(err_cnt), 32'd0);
    check("chk_good_frame_cnt", 32'(frame_cnt), 32'd3);
    check("chk_good_crc_value", crc_value, 32'h2144_DF1C);

    // Check mode, bit 0 of '5' flipped.
    chk_frame("chk_bad", 32'h3837_3634);
    expect_stat("chk_bad", 1'b1);
    check("chk_bad_err_cnt",   32'(err_cnt), 32'd1);
    check("chk_bad_frame_cnt", 32'(frame_cnt), 32'd4);

    // Backpressure while in APPEND and while the extra beat waits.
    send(32'h3433_3231, 1'b1, 1'b1, 2'd0, 1'b0);
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_sof     = 1'b1;
    s_eof     = 1'b1;
    s_data    = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp1_m_valid", 32'(m_valid), 32'd1);
      check("bp1_m_data",  m_data, 32'h3433_3231);
      check("bp1_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    cycles(1);
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp2_m_valid", 32'(m_valid), 32'd1);
      check("bp2_m_data",  m_data, 32'h9BE3_E0A3);
      check("bp2_m_eof",   32'(m_eof), 32'd1);
      check("bp2_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_s_ready", 32'(s_ready), 32'd1);
    cycles(2);
    expect_beat("bp_b0", 32'h3433_3231, 1'b1, 1'b0, 2'd0);
    expect_beat("bp_b1", 32'h9BE3_E0A3, 1'b0, 1'b1, 2'd0);
    check("bp_frame_cnt", 32'(frame_cnt), 32'd5);
    expect_stat("bp", 1'b0);

    // Reset in the middle of a frame, then replay the first frame.
    send(32'h3433_3231, 1'b1, 1'b0, 2'd0, 1'b0);
    send(32'h3837_3635, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid",   32'(m_valid), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_err_cnt",   32'(err_cnt), 32'd0);
    cycles(2);
    rst = 1'b1;
    mon_q.delete();
    stat_q.delete();
    cycles(1);
    gen_123456789("replay");
    check("replay_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
